// File: rtl/ad7768_cfg_seq.sv
`default_nettype none
// ad7768_cfg_seq: walks an external register table, issuing one write + readback SPI job per entry.
// Macro AD7768_CFG_SEQ_VERIFY_EN enables readback compare with bounded retry (default: readback ignored).
module ad7768_cfg_seq #(
  parameter int NUM_REGS    = 8,
  parameter int IDX_W       = 4,
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 1023,
  parameter int TMR_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [6:0]       tbl_addr,
  input  logic [7:0]       tbl_data,
  output logic             flag_sdo,
  output logic [7:0]       Addr1,
  output logic [7:0]       Addr2,
  output logic             ins1_RW,
  output logic             ins2_RW,
  output logic [7:0]       DATA_cmd1,
  output logic [7:0]       DATA_cmd2,
  input  logic             flag_end,
  input  logic [7:0]       sdo_data2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] err_idx,
  output logic [1:0]       err_code
);

  localparam int               RTY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

  state_t           state;
  logic [RTY_W-1:0] retry;
  logic [TMR_W-1:0] timer;
  logic             rd_match;

`ifdef AD7768_CFG_SEQ_VERIFY_EN
  assign rd_match = (sdo_data2 == DATA_cmd1);
`else
  // Readback is not compared in this build; every completed job counts as a match.
  logic unused_rd;
  assign unused_rd = ^sdo_data2;
  assign rd_match  = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      retry     <= '0;
      timer     <= '0;
      tbl_idx   <= '0;
      flag_sdo  <= 1'b0;
      Addr1     <= 8'h00;
      Addr2     <= 8'h00;
      ins1_RW   <= 1'b0;
      ins2_RW   <= 1'b0;
      DATA_cmd1 <= 8'h00;
      DATA_cmd2 <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_idx   <= '0;
      err_code  <= 2'b00;
    end else begin
      flag_sdo  <= 1'b0;
      ins1_RW   <= 1'b0;
      DATA_cmd2 <= 8'h00;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            tbl_idx  <= '0;
            retry    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            err_idx  <= '0;
            busy     <= 1'b1;
            ins2_RW  <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          Addr1     <= {1'b0, tbl_addr};
          Addr2     <= {1'b0, tbl_addr};
          DATA_cmd1 <= tbl_data;
          ins2_RW   <= 1'b1;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          flag_sdo <= 1'b1;
          timer    <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          // A completion arriving on the last allowed cycle still counts.
          if (flag_end) begin
            state <= S_CHECK;
          end else if (timer == TMO_LAST) begin
            err      <= 1'b1;
            err_code <= 2'b10;
            err_idx  <= tbl_idx;
            busy     <= 1'b0;
            ins2_RW  <= 1'b0;
            state    <= S_FAIL;
          end
        end
        S_CHECK: begin
          if (rd_match) begin
            if (tbl_idx == LAST_IDX) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              ins2_RW <= 1'b0;
              state   <= S_DONE;
            end else begin
              tbl_idx <= tbl_idx + 1'b1;
              retry   <= '0;
              state   <= S_LOAD;
            end
          end else if (retry < RTY_MAX) begin
            retry <= retry + 1'b1;
            state <= S_LOAD;
          end else begin
            err      <= 1'b1;
            err_code <= 2'b01;
            err_idx  <= tbl_idx;
            busy     <= 1'b0;
            ins2_RW  <= 1'b0;
            state    <= S_FAIL;
          end
        end
        default: begin
          busy    <= 1'b0;
          ins2_RW <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad7768_cfg_seq.sv
`default_nettype none
// tb_ad7768_cfg_seq: randomized self-checking bench; a transaction-level model predicts the job list and outcome.
module tb_ad7768_cfg_seq;

  localparam int NREG = 3;
  localparam int IDXW = 4;
  localparam int MAXR = 2;
  localparam int TMO  = 1023;
`ifdef AD7768_CFG_SEQ_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [IDXW-1:0] tbl_idx;
  logic [6:0]      tbl_addr;
  logic [7:0]      tbl_data;
  logic            flag_sdo;
  logic [7:0]      Addr1, Addr2, DATA_cmd1, DATA_cmd2;
  logic            ins1_RW, ins2_RW;
  logic            flag_end;
  logic [7:0]      sdo_data2;
  logic            busy, done, err;
  logic [IDXW-1:0] err_idx;
  logic [1:0]      err_code;

  always #20 clk = ~clk;

  ad7768_cfg_seq #(
    .NUM_REGS(NREG), .IDX_W(IDXW), .MAX_RETRY(MAXR), .TIMEOUT_CYC(TMO), .TMR_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .flag_sdo(flag_sdo),
    .Addr1(Addr1), .Addr2(Addr2), .ins1_RW(ins1_RW), .ins2_RW(ins2_RW),
    .DATA_cmd1(DATA_cmd1), .DATA_cmd2(DATA_cmd2), .flag_end(flag_end),
    .sdo_data2(sdo_data2), .busy(busy), .done(done), .err(err),
    .err_idx(err_idx), .err_code(err_code)
  );

  // Table lookup and per-job responder plan
  logic [6:0] tab_a [16];
  logic [7:0] tab_d [16];
  bit         plan_bad [32];
  bit         plan_to  [32];
  assign tbl_addr = tab_a[tbl_idx];
  assign tbl_data = tab_d[tbl_idx];

  // Model expectations
  logic [6:0] exp_a [32];
  logic [7:0] exp_d [32];
  int         exp_n, exp_idx, exp_code;
  bit         exp_done, exp_err;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Responder standing in for spi_sdo
  int         rjob = 0;
  int         rcnt;
  logic [7:0] rval;
  initial begin
    flag_end = 1'b0; sdo_data2 = 8'h00; rcnt = 0; rval = 8'h00;
    forever begin
      @(negedge clk);
      flag_end = 1'b0;
      if (!rst_n) begin
        rcnt = 0;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          flag_end  = 1'b1;
          sdo_data2 = rval;
        end
      end else if (flag_sdo) begin
        if (rjob < 32 && !plan_to[rjob]) begin
          rcnt = $urandom_range(1, 5);
          rval = plan_bad[rjob] ? ~DATA_cmd1 : DATA_cmd1;
        end
        rjob++;
      end
    end
  end

  // Per-cycle compare process
  int         cyc = 0, pulses = 0, last_end_cyc = -100, last_sdo_cyc = 0, err_rise_cyc = 0;
  logic       prev_sdo = 1'b0, prev_err = 1'b0;
  logic [6:0] obs_a [32];
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst_n) begin
        chk("ins1_RW_zero", ins1_RW, 0);
        chk("DATA_cmd2_zero", DATA_cmd2, 0);
        chk("ins2_RW_tracks_busy", ins2_RW, busy);
        chk("addr2_eq_addr1", Addr2, Addr1);
        chk("idx_in_range", tbl_idx < NREG, 1);
        chk("done_err_exclusive", done & err, 0);
        if (flag_sdo) begin
          chk("sdo_single_cycle", prev_sdo, 0);
          chk("sdo_while_busy", busy, 1);
          chk("sdo_gap_after_end", (cyc - last_end_cyc) >= 3, 1);
          if (pulses < exp_n) begin
            chk("job_addr", Addr1, {1'b0, exp_a[pulses]});
            chk("job_data", DATA_cmd1, exp_d[pulses]);
          end else begin
            chk("extra_pulse", pulses + 1, exp_n);
          end
          if (pulses < 32) obs_a[pulses] = Addr1[6:0];
          pulses++;
          last_sdo_cyc = cyc;
        end
        if (flag_end) last_end_cyc = cyc;
        if (err && !prev_err) err_rise_cyc = cyc;
        prev_sdo = flag_sdo;
        prev_err = err;
      end else begin
        prev_sdo = 1'b0;
        prev_err = 1'b0;
      end
    end
  end

  // Walk the table entry by entry, consuming one planned response per job
  task automatic build_model();
    int idx = 0;
    int r = 0;
    exp_n = 0; exp_done = 0; exp_err = 0; exp_idx = 0; exp_code = 0;
    for (int j = 0; j < 32; j++) begin
      exp_a[j] = tab_a[idx];
      exp_d[j] = tab_d[idx];
      exp_n++;
      if (plan_to[j]) begin
        exp_err = 1; exp_idx = idx; exp_code = 2;
        break;
      end
      if (VERIFY && plan_bad[j]) begin
        if (r < MAXR) r++;
        else begin
          exp_err = 1; exp_idx = idx; exp_code = 1;
          break;
        end
      end else begin
        idx++; r = 0;
        if (idx == NREG) begin
          exp_done = 1;
          break;
        end
      end
    end
  endtask

  task automatic clear_plan();
    for (int j = 0; j < 32; j++) begin
      plan_bad[j] = 1'b0;
      plan_to[j]  = 1'b0;
    end
  endtask

  task automatic fixed_table();
    tab_a[0] = 7'h04; tab_d[0] = 8'h35;
    tab_a[1] = 7'h05; tab_d[1] = 8'h08;
    tab_a[2] = 7'h06; tab_d[2] = 8'h01;
  endtask

  task automatic kick();
    build_model();
    pulses = 0;
    rjob = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_seq();
    int n = 0;
    kick();
    while (!(done || err) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("run_completes", n < 3000, 1);
    repeat (2) @(negedge clk);
    chk("end_done", done, exp_done);
    chk("end_err", err, exp_err);
    chk("end_err_idx", err_idx, exp_idx);
    chk("end_err_code", err_code, exp_code);
    chk("end_busy", busy, 0);
    chk("end_pulses", pulses, exp_n);
  endtask

  function automatic logic [63:0] all_outs();
    return {tbl_idx, flag_sdo, Addr1, Addr2, ins1_RW, ins2_RW, DATA_cmd1,
            DATA_cmd2, busy, done, err, err_idx, err_code};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      tab_a[i] = 7'h00;
      tab_d[i] = 8'h00;
    end
    clear_plan();
    exp_n = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain echo walk
    fixed_table(); clear_plan();
    run_seq();
    chk("c1_pulses", pulses, 3);
    chk("c1_addr0", obs_a[0], 7'h04);
    chk("c1_addr1", obs_a[1], 7'h05);
    chk("c1_addr2", obs_a[2], 7'h06);
    chk("c1_done", done, 1);

    // Entry 1 mismatches once
    clear_plan(); plan_bad[1] = 1'b1;
    run_seq();
    chk("c2_pulses", pulses, VERIFY ? 4 : 3);
    chk("c2_second_addr", obs_a[1], 7'h05);
    chk("c2_done", done, 1);
    chk("c2_code", err_code, 0);

    // Entry 2 always mismatches
    clear_plan(); plan_bad[2] = 1'b1; plan_bad[3] = 1'b1; plan_bad[4] = 1'b1;
    run_seq();
    chk("c3_pulses", pulses, VERIFY ? 5 : 3);
    chk("c3_last_addr", obs_a[pulses-1], 7'h06);
    chk("c3_err", err, VERIFY ? 1 : 0);
    chk("c3_err_idx", err_idx, VERIFY ? 2 : 0);
    chk("c3_code", err_code, VERIFY ? 1 : 0);
    chk("c3_done", done, VERIFY ? 0 : 1);

    // Never completes: watchdog
    clear_plan(); plan_to[0] = 1'b1;
    run_seq();
    chk("c4_wait_cycles", err_rise_cyc - last_sdo_cyc, 1023);
    chk("c4_err", err, 1);
    chk("c4_err_idx", err_idx, 0);
    chk("c4_code", err_code, 2);

    // Start ignored while busy, then async reset mid-WAIT
    clear_plan(); plan_to[0] = 1'b1;
    kick();
    repeat (8) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    chk("c5_restart_ignored", pulses, 1);
    chk("c5_still_busy", busy, 1);
    #5 rst_n = 1'b0;
    #1 chk("c5_async_reset", all_outs(), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_plan();
    run_seq();
    chk("c5_rerun_pulses", pulses, 3);
    chk("c5_rerun_done", done, 1);

    // Randomized tables and responder behaviour
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NREG; i++) begin
        tab_a[i] = 7'($urandom);
        tab_d[i] = 8'($urandom);
      end
      for (int j = 0; j < 32; j++) begin
        plan_bad[j] = ($urandom % 4) == 0;
        plan_to[j]  = ($urandom % 25) == 0;
      end
      run_seq();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
